csa_word_sequencer: RTL

//   Multi-byte add/subtract sequencer around one 8-bit conditional_sum_adder.
//   - Captures two (8*WORDS)-bit operands through a valid/ready handshake.
//   - Feeds the adder one byte per cycle, LSB first, and chains the carry between bytes in a register.
//   - Returns the full-width result, carry-out and signed overflow through a second valid/ready handshake.
//   - Makes the 8-bit adder usable as a wide ALU datapath.

---
 rtl/csa_word_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/csa_word_sequencer.sv
// Multi-byte add/subtract sequencer: streams operands byte-by-byte (LSB first)
// through one 8-bit conditional-sum adder, chaining the carry in a register.

module conditional_sum_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo0_s, lo1_s, hi0_s, hi1_s, lo_s, hi_s;

  // Each nibble is summed for both possible carries; the real carry then selects.
  assign lo0_s = {1'b0, a[3:0]} + {1'b0, b[3:0]};
  assign lo1_s = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'd1;
  assign hi0_s = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1_s = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
  assign lo_s  = cin      ? lo1_s : lo0_s;
  assign hi_s  = lo_s[4]  ? hi1_s : hi0_s;
  assign s     = {hi_s[3:0], lo_s[3:0]};
  assign cout  = hi_s[4];
endmodule

module csa_word_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [8*WORDS-1:0] x,
  input  logic [8*WORDS-1:0] y,
  input  logic               cin,
  input  logic               sub,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               overflow,
  output logic               busy
);
  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     xa_r, yb_r, sum_r;
  logic             cout_r, overflow_r;
  logic             start_ready_r, result_valid_r, busy_r;

  logic [W-1:0]     x_shift_s, y_shift_s;
  logic [7:0]       x_byte_s, y_byte_s, add_sum_s;
  logic             add_cout_s;

  // Select the current byte of the captured operands.
  always_comb begin
    x_shift_s = xa_r >> {idx_r, 3'b000};
    y_shift_s = yb_r >> {idx_r, 3'b000};
    x_byte_s  = x_shift_s[7:0];
    y_byte_s  = y_shift_s[7:0];
  end

  conditional_sum_adder u_adder (
    .a    (x_byte_s),
    .b    (y_byte_s),
    .cin  (carry_r),
    .s    (add_sum_s),
    .cout (add_cout_s)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      idx_r          <= {IDX_W{1'b0}};
      carry_r        <= 1'b0;
      xa_r           <= {W{1'b0}};
      yb_r           <= {W{1'b0}};
      sum_r          <= {W{1'b0}};
      cout_r         <= 1'b0;
      overflow_r     <= 1'b0;
      start_ready_r  <= 1'b1;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            xa_r          <= x;
            yb_r          <= sub ? ~y : y;
            carry_r       <= sub ? 1'b1 : cin;
            idx_r         <= {IDX_W{1'b0}};
            state_r       <= RUN;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_r == IDX_W'(i)) sum_r[8*i +: 8] <= add_sum_s;
          end
          carry_r <= add_cout_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(WORDS - 1)) begin
            cout_r         <= add_cout_s;
            // Signed overflow: equal operand signs but result sign differs.
            overflow_r     <= (xa_r[W-1] == yb_r[W-1]) && (add_sum_s[7] != xa_r[W-1]);
            state_r        <= DONE;
            result_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            start_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          start_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign sum          = sum_r;
  assign cout         = cout_r;
  assign overflow     = overflow_r;
endmodule
